bram_port_arbiter: RTL and testbench



---
 rtl/bram_arb_pkg.sv | 17 +
 rtl/bram_rr_picker.sv | 26 ++
 rtl/bram_port_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared state encoding, requester IDs and defaults for the BRAM port-A arbiter
package bram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    localparam int READ_LAT_DEF  = 1;
    localparam int MAX_BURST_DEF = 16;

endpackage

// File: rtl/bram_rr_picker.sv
// rtl/bram_rr_picker.sv - combinational 2-way round-robin choice with a requester-1 lock override
module bram_rr_picker
    import bram_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    input  logic lock_i,
    output logic valid_o,
    output logic grant_o
);

    // Lock keeps requester 1 on the port; otherwise a tie goes to whoever did not win last.
    always_comb begin
        valid_o = req0_i | req1_i;
        grant_o = REQ_CPU;
        if (lock_i && req1_i) begin
            grant_o = REQ_DMA;
        end else if (req0_i && req1_i) begin
            grant_o = ~last_grant_i;
        end else if (req1_i) begin
            grant_o = REQ_DMA;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin sharing of BRAM port A between CPU and DMA; burst lock under BRAM_ARB_BURST_EN
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int READ_LAT  = READ_LAT_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic          i_we0,
    input  logic          i_we1,
    input  logic [AW-1:0] i_addr0,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wdata0,
    input  logic [DW-1:0] i_wdata1,
    input  logic          i_lock1,
    output logic          o_ack0,
    output logic          o_ack1,
    output logic [DW-1:0] o_rdata,
    output logic          o_bram_en,
    output logic          o_bram_we,
    output logic [AW-1:0] o_bram_addr,
    output logic [DW-1:0] o_bram_din,
    input  logic [DW-1:0] i_bram_dout,
    output logic          o_busy
);

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic          wr_q, wr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          en_q, en_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;

    logic          pick_valid;
    logic          pick_grant;
    logic          pick_lock;

`ifdef BRAM_ARB_BURST_EN
    localparam logic [4:0] MAX_B5 = 5'(MAX_BURST);
    logic          lock_q, lock_d;
    logic [4:0]    bcnt_q, bcnt_d;
    assign pick_lock = lock_q;
`else
    logic          unused_cfg;
    assign unused_cfg = i_lock1 | (MAX_BURST != 0);
    assign pick_lock  = 1'b0;
`endif

    bram_rr_picker u_picker (
        .req0_i       (i_req0),
        .req1_i       (i_req1),
        .last_grant_i (last_grant_q),
        .lock_i       (pick_lock),
        .valid_o      (pick_valid),
        .grant_o      (pick_grant)
    );

    // Access sequencer: grant in IDLE, one enable cycle in ISSUE, read-latency wait, ack in RESP.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        cnt_d        = cnt_q;
        en_d         = en_q;
        we_d         = we_q;
        addr_d       = addr_q;
        din_d        = din_q;
        rdata_d      = rdata_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
`ifdef BRAM_ARB_BURST_EN
        lock_d       = lock_q;
        bcnt_d       = bcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d      = pick_grant;
                    last_grant_d = pick_grant;
                    en_d         = 1'b1;
                    if (pick_grant == REQ_DMA) begin
                        we_d   = i_we1;
                        wr_d   = i_we1;
                        addr_d = i_addr1;
                        din_d  = i_wdata1;
                    end else begin
                        we_d   = i_we0;
                        wr_d   = i_we0;
                        addr_d = i_addr0;
                        din_d  = i_wdata0;
                    end
                    state_d = ISSUE;
`ifdef BRAM_ARB_BURST_EN
                    if (pick_grant == REQ_DMA) begin
                        bcnt_d = bcnt_q + 5'd1;
                    end else begin
                        bcnt_d = 5'd0;
                        lock_d = 1'b0;
                    end
`endif
                end
            end
            ISSUE: begin
                en_d = 1'b0;
                we_d = 1'b0;
                if (wr_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d = 2'(READ_LAT - 1);
                    state_d = (READ_LAT <= 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
`ifdef BRAM_ARB_BURST_EN
                if (grant_q == REQ_DMA) begin
                    if (i_lock1 && (bcnt_q < MAX_B5)) begin
                        lock_d = 1'b1;
                    end else begin
                        lock_d = 1'b0;
                        bcnt_d = 5'd0;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // The ack and read capture happen on the edge that enters RESP.
        if (state_d == RESP && state_q != RESP) begin
            ack0_d = (grant_q == REQ_CPU);
            ack1_d = (grant_q == REQ_DMA);
            if (!wr_q) begin
                rdata_d = i_bram_dout;
            end
        end
    end

    // State and output registers; reset aborts any in-flight access immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            grant_q      <= REQ_CPU;
            last_grant_q <= REQ_DMA;
            wr_q         <= 1'b0;
            cnt_q        <= 2'd0;
            en_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            rdata_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
`ifdef BRAM_ARB_BURST_EN
            lock_q       <= 1'b0;
            bcnt_q       <= 5'd0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            en_q         <= en_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            rdata_q      <= rdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
`ifdef BRAM_ARB_BURST_EN
            lock_q       <= lock_d;
            bcnt_q       <= bcnt_d;
`endif
        end
    end

    assign o_ack0      = ack0_q;
    assign o_ack1      = ack1_q;
    assign o_rdata     = rdata_q;
    assign o_bram_en   = en_q;
    assign o_bram_we   = we_q;
    assign o_bram_addr = addr_q;
    assign o_bram_din  = din_q;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - directed self-checking bench for bram_port_arbiter with READ_LAT = 2
module tb_bram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1, lock1;
    logic [15:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        ack0, ack1;
    logic [7:0]  rdata;
    logic        bram_en, bram_we;
    logic [15:0] bram_addr;
    logic [7:0]  bram_din;
    logic [7:0]  bram_dout;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [int];
    logic       ack_who [$];
    logic [7:0] ack_dat [$];

    always #5 clk = ~clk;

    bram_port_arbiter #(.AW(16), .DW(8), .READ_LAT(2), .MAX_BURST(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req0      (req0),
        .i_req1      (req1),
        .i_we0       (we0),
        .i_we1       (we1),
        .i_addr0     (addr0),
        .i_addr1     (addr1),
        .i_wdata0    (wdata0),
        .i_wdata1    (wdata1),
        .i_lock1     (lock1),
        .o_ack0      (ack0),
        .o_ack1      (ack1),
        .o_rdata     (rdata),
        .o_bram_en   (bram_en),
        .o_bram_we   (bram_we),
        .o_bram_addr (bram_addr),
        .o_bram_din  (bram_din),
        .i_bram_dout (bram_dout),
        .o_busy      (busy)
    );

    // Synchronous read-first BRAM; unwritten bytes read as (addr[7:0] ^ 8'h5A).
    always @(posedge clk) begin
        if (bram_en) begin
            bram_dout <= mem.exists(int'(bram_addr)) ? mem[int'(bram_addr)] : (bram_addr[7:0] ^ 8'h5A);
            if (bram_we) mem[int'(bram_addr)] = bram_din;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Gather up to n acks within a cycle budget, checking every cycle that acks never overlap.
    task automatic collect(input int n, input int budget);
        int c;
        c = 0;
        ack_who.delete();
        ack_dat.delete();
        while (ack_who.size() < n && c < budget) begin
            @(negedge clk);
            c++;
            chk("ack_overlap", 32'(ack0 & ack1), 32'd0);
            if (ack0) begin ack_who.push_back(1'b0); ack_dat.push_back(rdata); end
            if (ack1) begin ack_who.push_back(1'b1); ack_dat.push_back(rdata); end
        end
        chk("ack_count", 32'(ack_who.size()), 32'(n));
    endtask

    logic exp_who [5];

    initial begin
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
        addr0 = 16'h0042; addr1 = 16'h0000; wdata0 = 8'h00; wdata1 = 8'h00;

        // Reset held with a pending request: everything quiet.
        step(); step(); step();
        chk("rst_en",    32'(bram_en),   32'd0);
        chk("rst_we",    32'(bram_we),   32'd0);
        chk("rst_ack0",  32'(ack0),      32'd0);
        chk("rst_ack1",  32'(ack1),      32'd0);
        chk("rst_rdata", 32'(rdata),     32'd0);
        chk("rst_addr",  32'(bram_addr), 32'd0);
        chk("rst_din",   32'(bram_din),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);

        // Release: pending read of 0x0042 by requester 0.
        rst_n = 1'b1;
        step();
        chk("rel_en",   32'(bram_en),   32'd1);
        chk("rel_addr", 32'(bram_addr), 32'h0042);
        chk("rel_busy", 32'(busy),      32'd1);
        step();
        chk("rel_en_off", 32'(bram_en), 32'd0);
        chk("rel_noack",  32'(ack0),    32'd0);
        step();
        chk("rel_ack0",  32'(ack0),  32'd1);
        chk("rel_ack1",  32'(ack1),  32'd0);
        chk("rel_rdata", 32'(rdata), 32'h18);
        req0 = 1'b0;
        step();

        // Single write by requester 0: en at k+1, ack at k+2.
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h1234; wdata0 = 8'hA5;
        step();
        chk("wr_en",   32'(bram_en),   32'd1);
        chk("wr_we",   32'(bram_we),   32'd1);
        chk("wr_addr", 32'(bram_addr), 32'h1234);
        chk("wr_din",  32'(bram_din),  32'hA5);
        chk("wr_early_ack", 32'(ack0), 32'd0);
        step();
        chk("wr_ack0",  32'(ack0),    32'd1);
        chk("wr_en_off", 32'(bram_en), 32'd0);
        chk("wr_we_off", 32'(bram_we), 32'd0);
        chk("wr_rdata_hold", 32'(rdata), 32'h18);
        req0 = 1'b0; we0 = 1'b0;
        step();

        // Single read by requester 1 with READ_LAT = 2: ack at k+3.
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h1234;
        step();
        chk("rd_en",   32'(bram_en),   32'd1);
        chk("rd_we",   32'(bram_we),   32'd0);
        chk("rd_addr", 32'(bram_addr), 32'h1234);
        step();
        chk("rd_en_once", 32'(bram_en), 32'd0);
        chk("rd_noack",   32'(ack1),    32'd0);
        step();
        chk("rd_ack1",  32'(ack1),  32'd1);
        chk("rd_ack0",  32'(ack0),  32'd0);
        chk("rd_rdata", 32'(rdata), 32'hA5);
        req1 = 1'b0;
        step();

        // Write by requester 1 keeps the last read data on o_rdata.
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0010; wdata1 = 8'h3C;
        step();
        chk("wr1_en", 32'(bram_en), 32'd1);
        step();
        chk("wr1_ack1",  32'(ack1),  32'd1);
        chk("wr1_rdata", 32'(rdata), 32'hA5);
        req1 = 1'b0; we1 = 1'b0;
        step();

        // Contention: both reads held, last grant was 1, so service is 0,1,0,1.
        req0 = 1'b1; addr0 = 16'h0101; req1 = 1'b1; addr1 = 16'h0203;
        collect(4, 40);
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < ack_who.size()) begin
                chk($sformatf("rr_who%0d", i), 32'(ack_who[i]), 32'(i % 2));
                chk($sformatf("rr_dat%0d", i), 32'(ack_dat[i]), (i % 2 == 0) ? 32'h5B : 32'h59);
            end
        end
        step();

        // Lock held by requester 1; requester 0 joins after the first ack.
        req1 = 1'b1; lock1 = 1'b1; addr1 = 16'h0203;
        collect(1, 10);
        req0 = 1'b1; addr0 = 16'h0101;
        collect(4, 60);
        req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
`ifdef BRAM_ARB_BURST_EN
        exp_who[0] = 1'b1; exp_who[1] = 1'b1; exp_who[2] = 1'b1; exp_who[3] = 1'b0;
`else
        exp_who[0] = 1'b0; exp_who[1] = 1'b1; exp_who[2] = 1'b0; exp_who[3] = 1'b1;
`endif
        for (int i = 0; i < 4; i++) begin
            if (i < ack_who.size()) begin
                chk($sformatf("lock_who%0d", i), 32'(ack_who[i]), 32'(exp_who[i]));
            end
        end
        step();

        // Reset in the WAIT cycle of a read: abort with no ack.
        req0 = 1'b1; addr0 = 16'h0042;
        step();
        chk("mid_en", 32'(bram_en), 32'd1);
        step();
        chk("mid_busy_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy_rst", 32'(busy),    32'd0);
        chk("mid_en_rst",   32'(bram_en), 32'd0);
        chk("mid_we_rst",   32'(bram_we), 32'd0);
        step();
        chk("mid_noack0_a", 32'(ack0), 32'd0);
        step();
        chk("mid_noack0_b", 32'(ack0), 32'd0);
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h1234;
        rst_n = 1'b1;
        collect(2, 30);
        req0 = 1'b0; req1 = 1'b0;
        if (ack_who.size() == 2) begin
            chk("post_who0", 32'(ack_who[0]), 32'd0);
            chk("post_dat0", 32'(ack_dat[0]), 32'h18);
            chk("post_who1", 32'(ack_who[1]), 32'd1);
            chk("post_dat1", 32'(ack_dat[1]), 32'hA5);
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
